// File: rtl/kyber_pkg.sv
// kyber_pkg: definitions shared by the byte-to-bit converter and its users.
//   BITS_PER_BYTE : width of one source byte slot in the output vector
//   state_e       : converter FSM state encoding
package kyber_pkg;

  localparam int BITS_PER_BYTE = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bytes_to_bits_if.sv
// bytes_to_bits_if: bundles the converter's request and result signals so
// a driver and the converter can be wired up with one instance.
//   start      : one-cycle conversion request
//   B          : source byte slots
//   len        : number of valid bytes (clamped to BYTE_COUNT by the converter)
//   b          : converted bit vector, LSB-first per byte
//   busy, done : conversion in progress / one-cycle completion pulse
// master drives the request side, slave is the converter side.
interface bytes_to_bits_if
  import kyber_pkg::*;
#(
  parameter int BYTE_COUNT = 128,
  parameter int BIT_COUNT  = 1024
);

  logic                           start;
  logic [BITS_PER_BYTE-1:0]       B [BYTE_COUNT-1:0];
  logic [$clog2(BYTE_COUNT):0]    len;
  logic [BIT_COUNT-1:0]           b;
  logic                           busy;
  logic                           done;

  modport master (output start, B, len, input b, busy, done);
  modport slave  (input start, B, len, output b, busy, done);

endinterface

// File: rtl/bytes_to_bits.sv
// bytes_to_bits: serial byte-array to bit-vector converter, one byte per
// clock. On an accepted start the source bytes and clamped length are
// snapshotted, b is cleared, and bytes are then written LSB-first into b.
//   clk, rst : clock, synchronous active-high reset
//   start    : conversion request, ignored while busy
//   B, len   : source bytes and valid-byte count, sampled on start
//   b        : registered result, held after completion until next start
//   busy     : high in RUN and DONE
//   done     : one-cycle pulse, registered one cycle after DONE
//
// state   | meaning
// --------+---------------------------------------------------
// ST_IDLE | waiting for start; b holds the last result
// ST_RUN  | writing byte idx into b, one byte per cycle
// ST_DONE | last byte written; done pulses on the following cycle
module bytes_to_bits
  import kyber_pkg::*;
#(
  parameter int BYTE_COUNT = 128,
  parameter int BIT_COUNT  = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [BITS_PER_BYTE-1:0]    B [BYTE_COUNT-1:0],
  input  logic [$clog2(BYTE_COUNT):0] len,
  output logic [BIT_COUNT-1:0]        b,
  output logic                        busy,
  output logic                        done
);

  localparam int LW = $clog2(BYTE_COUNT) + 1;

  if (BIT_COUNT != BITS_PER_BYTE * BYTE_COUNT) begin : g_width_check
    $error("bytes_to_bits: BIT_COUNT must equal 8*BYTE_COUNT");
  end

  state_e                   state_q, state_d;
  logic [BITS_PER_BYTE-1:0] bytes_q [BYTE_COUNT-1:0];
  logic [LW-1:0]            len_q;
  logic [LW-1:0]            idx_q;
  logic [BIT_COUNT-1:0]     b_q;
  logic                     done_q;

  logic [LW-1:0]            len_eff;
  logic                     accept;
  logic                     last_byte;

  assign len_eff   = (len > LW'(BYTE_COUNT)) ? LW'(BYTE_COUNT) : len;
  assign accept    = (state_q == ST_IDLE) && start;
  // len_q is at least 1 whenever RUN is entered, so the subtraction never wraps there.
  assign last_byte = (idx_q == len_q - LW'(1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = (len_eff != '0) ? ST_RUN : ST_DONE;
      ST_RUN:  if (last_byte) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Snapshot of the source bytes; decouples the conversion from later B changes.
  always_ff @(posedge clk) begin
    if (accept) bytes_q <= B;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_q    <= '0;
      idx_q  <= '0;
      len_q  <= '0;
      done_q <= 1'b0;
    end else begin
      // done trails DONE by one cycle so the pulse lands after b is final.
      done_q <= (state_q == ST_DONE);
      if (accept) begin
        len_q <= len_eff;
        idx_q <= '0;
        b_q   <= '0;
      end else if (state_q == ST_RUN) begin
        for (int i = 0; i < BYTE_COUNT; i++) begin
          if (idx_q == LW'(i)) b_q[i*BITS_PER_BYTE +: BITS_PER_BYTE] <= bytes_q[i];
        end
        idx_q <= idx_q + LW'(1);
      end
    end
  end

  assign b    = b_q;
  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_bytes_to_bits.sv
// tb_bytes_to_bits: directed bench for bytes_to_bits with a cycle-level
// reference model (edges since accepted start vs. clamped length) checked
// every cycle, plus literal expectations for the named scenarios.
module tb_bytes_to_bits;
  import kyber_pkg::*;

  localparam int BC = 128;
  localparam int BW = 1024;
  localparam int LW = $clog2(BC) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bytes_to_bits_if #(.BYTE_COUNT(BC), .BIT_COUNT(BW)) bus ();

  bytes_to_bits #(.BYTE_COUNT(BC), .BIT_COUNT(BW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (bus.start),
    .B     (bus.B),
    .len   (bus.len),
    .b     (bus.b),
    .busy  (bus.busy),
    .done  (bus.done)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int edge_cnt = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_vec(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    int fb = -1;
    n_checks++;
    for (int i = BC - 1; i >= 0; i--)
      if (act[8*i +: 8] !== exp[8*i +: 8]) fb = i;
    if (fb < 0) n_pass++;
    else $display("FAIL %s: byte %0d is %02h expected %02h", name, fb, act[8*fb +: 8], exp[8*fb +: 8]);
  endtask

  // Reference model: after an accepted start with clamped length L, the
  // k-th following edge has written min(k,L) bytes; busy while k<=L;
  // done exactly at k==L+1.
  bit             m_valid  = 1'b0;
  bit             m_active = 1'b0;
  bit             m_busy   = 1'b0;
  bit             m_done   = 1'b0;
  int             m_k      = 0;
  int             m_L      = 0;
  logic [7:0]     m_bytes [BC];
  logic [BW-1:0]  m_b      = '0;

  function automatic logic [BW-1:0] pack_first(input int k);
    logic [BW-1:0] v = '0;
    for (int i = 0; i < k; i++) v[8*i +: 8] = m_bytes[i];
    return v;
  endfunction

  always @(posedge clk) begin
    edge_cnt++;
    m_valid = 1'b1;
    if (rst) begin
      m_active = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_b = '0;
    end else if (!m_busy && bus.start) begin
      for (int i = 0; i < BC; i++) m_bytes[i] = bus.B[i];
      m_L = (int'(bus.len) > BC) ? BC : int'(bus.len);
      m_k = 0; m_active = 1'b1; m_busy = 1'b1; m_done = 1'b0; m_b = '0;
    end else if (m_active) begin
      m_k++;
      m_b    = pack_first((m_k < m_L) ? m_k : m_L);
      m_busy = (m_k <= m_L);
      m_done = (m_k == m_L + 1);
      if (m_done) m_active = 1'b0;
    end else begin
      m_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk(bus.busy === m_busy, "model_busy", 64'(bus.busy), 64'(m_busy));
      chk(bus.done === m_done, "model_done", 64'(bus.done), 64'(m_done));
      chk_vec("model_b", bus.b, m_b);
    end
  end

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < BC; i++) bus.B[i] = v;
  endtask

  // Waits for done after a start pulse; lat is edges from the start edge.
  task automatic wait_done(input int s, output int lat, inout int busy_cyc);
    bit ok = 1'b0;
    lat = -1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (bus.done) begin
        ok  = 1'b1;
        lat = edge_cnt - s;
        break;
      end
      if (bus.busy) busy_cyc++;
    end
    chk(ok, "done_timeout", 64'(ok), 64'd1);
  endtask

  task automatic run_conv(input int ln, output int lat, output int busy_cyc);
    int s;
    @(negedge clk);
    bus.len   = LW'(ln);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    s = edge_cnt;
    busy_cyc = bus.busy ? 1 : 0;
    wait_done(s, lat, busy_cyc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bc, s, done_cnt;
    logic [BW-1:0] exp_v;

    bus.start = 1'b0;
    bus.len   = '0;
    fill(8'h00);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_vec("reset_b", bus.b, '0);
    chk(bus.busy == 1'b0, "reset_busy", 64'(bus.busy), 64'd0);
    chk(bus.done == 1'b0, "reset_done", 64'(bus.done), 64'd0);
    rst = 1'b0;

    // Basic mapping
    fill(8'h00);
    bus.B[0] = 8'h01;
    bus.B[1] = 8'h80;
    run_conv(2, lat, bc);
    chk(lat == 3, "basic_latency", 64'(lat), 64'd3);
    chk_vec("basic_b", bus.b, BW'(16'h8001));

    // Zero length
    fill(8'hC3);
    run_conv(0, lat, bc);
    chk(lat == 1, "zero_latency", 64'(lat), 64'd1);
    chk(bc == 1, "zero_busy_cycles", 64'(bc), 64'd1);
    chk_vec("zero_b", bus.b, '0);

    // Full length
    fill(8'hFF);
    run_conv(128, lat, bc);
    chk(lat == 129, "full_latency", 64'(lat), 64'd129);
    chk_vec("full_b", bus.b, {BW{1'b1}});

    // Clamp: len 128 and len 200 must both give the full pattern
    exp_v = '0;
    for (int i = 0; i < BC; i++) begin
      bus.B[i] = 8'(i * 7 + 3);
      exp_v[8*i +: 8] = 8'(i * 7 + 3);
    end
    run_conv(128, lat, bc);
    chk_vec("pattern128_b", bus.b, exp_v);
    run_conv(200, lat, bc);
    chk(lat == 129, "clamp_latency", 64'(lat), 64'd129);
    chk_vec("clamp200_b", bus.b, exp_v);

    // Masking of bytes beyond len
    fill(8'h00);
    bus.B[0] = 8'h11; bus.B[1] = 8'h22; bus.B[2] = 8'h33; bus.B[3] = 8'hAA;
    run_conv(3, lat, bc);
    chk(bus.b[31:24] == 8'h00, "mask_byte3", 64'(bus.b[31:24]), 64'd0);
    chk_vec("mask_b", bus.b, BW'(24'h332211));

    // Second start and B change mid-run are ignored
    exp_v = '0;
    for (int i = 0; i < BC; i++) bus.B[i] = 8'(i + 1);
    for (int i = 0; i < 10; i++) exp_v[8*i +: 8] = 8'(i + 1);
    @(negedge clk);
    bus.len = LW'(10); bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    s = edge_cnt;
    bc = 1;
    repeat (3) @(negedge clk);
    bus.start = 1'b1; bus.len = LW'(5); fill(8'h5A);
    @(negedge clk);
    bus.start = 1'b0;
    bc = 0;
    wait_done(s, lat, bc);
    chk(lat == 11, "busy_latency", 64'(lat), 64'd11);
    chk_vec("busy_b", bus.b, exp_v);

    // Mid-run reset aborts without done
    fill(8'h77);
    @(negedge clk);
    bus.len = LW'(20); bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_vec("abort_b", bus.b, '0);
    chk(bus.busy == 1'b0, "abort_busy", 64'(bus.busy), 64'd0);
    done_cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    chk(done_cnt == 0, "abort_no_done", 64'(done_cnt), 64'd0);

    // Start accepted in the cycle done is high
    fill(8'h3C);
    run_conv(1, lat, bc);
    chk(lat == 2, "single_latency", 64'(lat), 64'd2);
    fill(8'h96);
    bus.len = LW'(1); bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk(bus.busy == 1'b1, "b2b_accept_busy", 64'(bus.busy), 64'd1);
    s = edge_cnt;
    bc = 1;
    wait_done(s, lat, bc);
    chk(lat == 2, "b2b_latency", 64'(lat), 64'd2);
    chk_vec("b2b_b", bus.b, BW'(8'h96));

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
